// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-expansion definitions: schedule sizes, round constants,
// forward S-box table and the controller state type.
package aes_key_pkg;

    localparam int NK = 4;
    localparam int NR = 10;
    localparam int NW = 44;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } ks_state_e;

    localparam logic [7:0] RCON [NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Rounds outside 1..NR return zero so the lookup is safe for any counter value.
    function automatic logic [7:0] rcon_for_round(input logic [3:0] rnd);
        if (rnd == 4'd0 || rnd > 4'(NR)) return 8'h00;
        return RCON[rnd - 4'd1];
    endfunction

endpackage

// File: rtl/key_schedule_gen_if.sv
// Key-load and round-key stream bundle between a consumer (master) and the
// key schedule generator (slave).
interface key_schedule_gen_if;
    logic [127:0] key_in;
    logic         key_load;
    logic         rk_ready;
    logic         rk_valid;
    logic [31:0]  rk_word;
    logic [3:0]   rk_round;
    logic [1:0]   rk_index;
    logic         busy;
    logic         done;

    modport master (
        output key_in, key_load, rk_ready,
        input  rk_valid, rk_word, rk_round, rk_index, busy, done
    );

    modport slave (
        input  key_in, key_load, rk_ready,
        output rk_valid, rk_word, rk_round, rk_index, busy, done
    );
endinterface

// File: rtl/key_sub_word.sv
// SubWord: four parallel forward S-box lookups on an already rotated word.
module key_sub_word
    import aes_key_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);
    assign word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                       SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};
endmodule

// File: rtl/key_schedule_gen.sv
// AES-128 key expansion streamer: emits w[0..43] one word per accepted transfer.
// Define KEY_SCHED_ZEROIZE_EN to wipe the window and output word on completion.
module key_schedule_gen
    import aes_key_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    key_schedule_gen_if.slave  bus
);
    ks_state_e        state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [3:0][31:0] win_q, win_d;
    logic [31:0]      rk_word_q, rk_word_d;
    logic [3:0]       rk_round_q, rk_round_d;
    logic [1:0]       rk_index_q, rk_index_d;
    logic             rk_valid_q, rk_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [5:0]       next_idx;
    logic [31:0]      rot_word, sub_word, temp_word, new_word;
    logic             xfer, last_xfer;

    // win_q[3] is the newest word w[cnt], win_q[0] is w[cnt-3] once cnt >= 3.
    assign next_idx  = cnt_q + 6'd1;
    assign rot_word  = {win_q[3][23:0], win_q[3][31:24]};
    assign temp_word = (next_idx[1:0] == 2'b00)
                     ? (sub_word ^ {rcon_for_round(next_idx[5:2]), 24'h000000})
                     : win_q[3];
    assign new_word  = win_q[0] ^ temp_word;
    assign xfer      = rk_valid_q & bus.rk_ready;
    assign last_xfer = xfer & (cnt_q == 6'(NW - 1));

    key_sub_word u_sub_word (
        .word_in  (rot_word),
        .word_out (sub_word)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        rk_word_d  = rk_word_q;
        rk_round_d = rk_round_q;
        rk_index_d = rk_index_q;
        rk_valid_d = rk_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.key_load) begin
                    state_d    = ST_EMIT;
                    cnt_d      = 6'd0;
                    win_d      = {bus.key_in[31:0], bus.key_in[63:32],
                                  bus.key_in[95:64], bus.key_in[127:96]};
                    rk_word_d  = bus.key_in[127:96];
                    rk_round_d = 4'd0;
                    rk_index_d = 2'd0;
                    rk_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_EMIT: begin
                if (last_xfer) begin
                    state_d    = ST_IDLE;
                    rk_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
`ifdef KEY_SCHED_ZEROIZE_EN
                    win_d      = '0;
                    rk_word_d  = 32'h0;
`else
                    win_d      = win_q;
                    rk_word_d  = rk_word_q;
`endif
                end else if (xfer) begin
                    cnt_d      = next_idx;
                    rk_round_d = next_idx[5:2];
                    rk_index_d = next_idx[1:0];
                    // The first four words come straight from the loaded key.
                    if (cnt_q < 6'(NK - 1)) begin
                        rk_word_d = win_q[next_idx[1:0]];
                    end else begin
                        win_d     = {new_word, win_q[3], win_q[2], win_q[1]};
                        rk_word_d = new_word;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            win_q      <= '0;
            rk_word_q  <= 32'h0;
            rk_round_q <= 4'd0;
            rk_index_q <= 2'd0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            rk_word_q  <= rk_word_d;
            rk_round_q <= rk_round_d;
            rk_index_q <= rk_index_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_word  = rk_word_q;
    assign bus.rk_round = rk_round_q;
    assign bus.rk_index = rk_index_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
